mem_wb_stage: RTL

- Memory stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Sits directly downstream of the EX/MEM latch and consumes its outputs.
- Runs the data-cache request/hit handshake and raises a stall while an access is outstanding.
- Selects writeback data and latches the writeback controls plus a sticky halt for the WB stage and register file.

---
 rtl/mem_wb_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory stage plus MEM/WB pipeline register of a 5-stage MIPS pipeline.
// Takes the EX/MEM latch outputs and runs the data-cache request/hit
// handshake. While an access is outstanding it raises mem_stall. It selects
// the writeback data and latches the writeback controls, a sticky halt and a
// sticky memory-timeout error for the WB stage and the register file.
//
// Ports
//   CLK, RST            clock (rising edge); asynchronous active-high reset
//   ihit                fetch hit; qualifies pipeline advance
//   flush               turn the next MEM/WB capture into a bubble
//   dREN_in, dWEN_in    EX/MEM load / store
//   addr_in, store_in   memory address (ALU result) / store data
//   MemtoReg_in         writeback takes load data
//   wdatasrc_in         non-load writeback source: 1 = pcp4, else ALU
//   WSel_in, WEN_in     destination register / register write enable
//   pcp4_in             PC+4
//   HALT_in             halt instruction in MEM
//   dhit, dmemload      data-cache hit/ack and read data
//   dmemREN, dmemWEN    data-cache read / write request
//   dmemaddr, dmemstore data-cache address / write data
//   mem_stall           hold all upstream stages
//   WEN_out, WSel_out,
//   wdata_out           MEM/WB writeback controls and data
//   halt_out, err_out   sticky halt / sticky memory-timeout error
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        flush,
    input  logic        dREN_in,
    input  logic        dWEN_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_in,
    input  logic        MemtoReg_in,
    input  logic [1:0]  wdatasrc_in,
    input  logic [4:0]  WSel_in,
    input  logic        WEN_in,
    input  logic [31:0] pcp4_in,
    input  logic        HALT_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        WEN_out,
    output logic [4:0]  WSel_out,
    output logic [31:0] wdata_out,
    output logic        halt_out,
    output logic        err_out
);

    // Access-handshake states.
    localparam logic [1:0] S_IDLE = 2'd0;  // no access outstanding
    localparam logic [1:0] S_WAIT = 2'd1;  // request issued, waiting for dhit
    localparam logic [1:0] S_DONE = 2'd2;  // hit taken, waiting for ihit

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ldbuf_q, ldbuf_d;
    logic             err_q, err_d;
    logic             wen_q, wen_d;
    logic [4:0]       wsel_q, wsel_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             halt_q, halt_d;

    logic        active;
    logic        mem_op;
    logic        advance;
    logic [31:0] load_data;
    logic [31:0] sel_data;

    // A halted core issues nothing. Reset also silences the stage, so a
    // request still presented by a not-yet-cleared EX/MEM latch is dropped.
    assign active  = ~RST & ~halt_q;
    assign mem_op  = (dREN_in | dWEN_in) & active;

    assign dmemaddr  = addr_in;
    assign dmemstore = store_in;
    // Both enables may be raised together; the cache sees one access.
    assign dmemREN   = dREN_in & active & (state_q != S_DONE);
    assign dmemWEN   = dWEN_in & active & (state_q != S_DONE);

    // Drops in the dhit cycle itself, so a same-cycle hit costs no stall.
    assign mem_stall = mem_op & (state_q != S_DONE) & ~dhit;
    assign advance   = ihit & ~mem_stall;

    // After a hit that arrived while fetch was stalled, the cache may have
    // moved on, so the buffered copy is the only valid load data in DONE.
    assign load_data = (state_q == S_DONE) ? ldbuf_q : dmemload;

    always_comb begin
        if (MemtoReg_in) begin
            sel_data = load_data;
        end else if (wdatasrc_in == 2'd1) begin
            sel_data = pcp4_in;
        end else begin
            sel_data = addr_in;  // 0 and the reserved codes 2/3
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM, wait counter, load buffer and timeout flag.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case leaves it unassigned; that is what keeps this free of latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        ldbuf_d = ldbuf_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (mem_op && dhit && !ihit) begin
                    state_d = S_DONE;
                    ldbuf_d = dmemload;
                end else if (mem_op && !dhit) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end

            S_WAIT: begin
                if (!mem_op) begin
                    // Upstream withdrew the op; nothing left to wait for.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (dhit) begin
                    if (ihit) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        ldbuf_d = dmemload;
                    end
                end else if (cnt_q == MAX_CNT) begin
                    // Counter parks at the limit; the request stays up.
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                if (ihit) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB register: moves only when the whole pipeline advances.
    // ------------------------------------------------------------------
    always_comb begin
        wen_d   = wen_q;
        wsel_d  = wsel_q;
        wdata_d = wdata_q;
        halt_d  = halt_q;

        if (advance) begin
            if (flush) begin
                wen_d   = 1'b0;
                wsel_d  = '0;
                wdata_d = '0;
            end else begin
                wen_d   = WEN_in;
                wsel_d  = WSel_in;
                wdata_d = sel_data;
                halt_d  = halt_q | HALT_in;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            // NOTE: the load buffer is a single word, not a RAM, so it is
            // reset like any other register and never carries X into WB.
            ldbuf_q <= '0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            wsel_q  <= '0;
            wdata_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ldbuf_q <= ldbuf_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            wsel_q  <= wsel_d;
            wdata_q <= wdata_d;
            halt_q  <= halt_d;
        end
    end

    assign WEN_out   = wen_q;
    assign WSel_out  = wsel_q;
    assign wdata_out = wdata_q;
    assign halt_out  = halt_q;
    assign err_out   = err_q;

endmodule
